contador_ud_ctrl: RTL and testbench

- Controller and arbiter that sequences a shared up/down counter (W-bit, single-cycle up/down inputs) between two requesters: an increment source and a decrement source.
- Rising edges on each request line are queued in per-side pending counters.
- Pending requests are served one at a time, round-robin, with a programmable hold-off between operations.
- Limits are enforced against the counter's live value: increments at MAX_COUNT and decrements at 0 are rejected, never issued.

---
 rtl/contador_ud_ctrl.sv | 170 +++++++++++++++++
 tb/tb_contador_ud_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_ud_ctrl.sv
// contador_ud_ctrl: arbitrates increment/decrement requests onto a shared
// up/down counter. Request edges are queued per side, served one at a time in
// round-robin order, checked against the counter's live value, and spaced by a
// programmable hold-off so each limit check sees the previous strobe's result.
module contador_ud_ctrl #(
   parameter int W         = 4,
   parameter int MAX_COUNT = 15,
   parameter int P         = 3,
   parameter int GAP       = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_req,
   input  logic         dec_req,
   input  logic [W-1:0] count,
   output logic         up,
   output logic         down,
   output logic         full,
   output logic         empty,
   output logic         busy,
   output logic         reject,
   output logic         q_ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_HOLD
   } state_t;

   typedef enum logic {
      G_INC,
      G_DEC
   } grant_t;

   localparam int              HW       = $clog2(GAP + 1);
   localparam logic [W-1:0]    MAX_W    = W'(MAX_COUNT);
   localparam logic [P-1:0]    PEND_MAX = '1;
   localparam logic [HW-1:0]   GAP_W    = HW'(GAP);

   state_t        state_q, state_d;
   grant_t        last_grant_q, last_grant_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [P-1:0]  inc_pend_q, inc_pend_d;
   logic [P-1:0]  dec_pend_q, dec_pend_d;
   logic          inc_prev_q, dec_prev_q;
   logic          up_q, up_d;
   logic          down_q, down_d;
   logic          reject_q, reject_d;
   logic          q_ovf_q, q_ovf_d;

   logic          inc_edge, dec_edge;
   logic          inc_consume, dec_consume;

   // Rising-edge detection on the already-synchronous request levels.
   assign inc_edge = inc_req & ~inc_prev_q;
   assign dec_edge = dec_req & ~dec_prev_q;

   // Arbitration and sequencing: pick a side in IDLE, strobe in ISSUE, wait in HOLD.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (which would infer a latch).
      state_d      = state_q;
      last_grant_d = last_grant_q;
      hold_d       = hold_q;
      up_d         = 1'b0;
      down_d       = 1'b0;
      reject_d     = 1'b0;
      inc_consume  = 1'b0;
      dec_consume  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if ((inc_pend_q != '0) && (dec_pend_q != '0)) begin
               // Both sides waiting: the side that did not win last time goes first.
               if (last_grant_q == G_DEC) inc_consume = 1'b1;
               else                       dec_consume = 1'b1;
            end else if (inc_pend_q != '0) begin
               inc_consume = 1'b1;
            end else if (dec_pend_q != '0) begin
               dec_consume = 1'b1;
            end

            // The limit check uses the counter value seen in this very cycle.
            if (inc_consume) begin
               last_grant_d = G_INC;
               state_d      = S_ISSUE;
               if (count == MAX_W) reject_d = 1'b1;
               else                up_d     = 1'b1;
            end else if (dec_consume) begin
               last_grant_d = G_DEC;
               state_d      = S_ISSUE;
               if (count == '0) reject_d = 1'b1;
               else             down_d   = 1'b1;
            end
         end

         S_ISSUE: begin
            state_d = S_HOLD;
            hold_d  = GAP_W;
         end

         S_HOLD: begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Pending-request counters: queue edges, drop and flag edges at saturation.
   always_comb begin
      inc_pend_d = inc_pend_q;
      dec_pend_d = dec_pend_q;
      q_ovf_d    = 1'b0;

      if (inc_edge && !inc_consume) begin
         if (inc_pend_q == PEND_MAX) q_ovf_d    = 1'b1;
         else                        inc_pend_d = inc_pend_q + P'(1);
      end else if (!inc_edge && inc_consume) begin
         inc_pend_d = inc_pend_q - P'(1);
      end

      if (dec_edge && !dec_consume) begin
         if (dec_pend_q == PEND_MAX) q_ovf_d    = 1'b1;
         else                        dec_pend_d = dec_pend_q + P'(1);
      end else if (!dec_edge && dec_consume) begin
         dec_pend_d = dec_pend_q - P'(1);
      end
   end

   // State and output registers; reset discards queued work and any in-flight operation.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= G_DEC;
         hold_q       <= '0;
         inc_pend_q   <= '0;
         dec_pend_q   <= '0;
         inc_prev_q   <= 1'b0;
         dec_prev_q   <= 1'b0;
         up_q         <= 1'b0;
         down_q       <= 1'b0;
         reject_q     <= 1'b0;
         q_ovf_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         hold_q       <= hold_d;
         inc_pend_q   <= inc_pend_d;
         dec_pend_q   <= dec_pend_d;
         inc_prev_q   <= inc_req;
         dec_prev_q   <= dec_req;
         up_q         <= up_d;
         down_q       <= down_d;
         reject_q     <= reject_d;
         q_ovf_q      <= q_ovf_d;
      end
   end

   assign up     = up_q;
   assign down   = down_q;
   assign reject = reject_q;
   assign q_ovf  = q_ovf_q;
   assign full   = (count == MAX_W);
   assign empty  = (count == '0);
   assign busy   = (state_q != S_IDLE) || (inc_pend_q != '0) || (dec_pend_q != '0);

endmodule

// File: tb/tb_contador_ud_ctrl.sv
// Testbench for contador_ud_ctrl. A small up/down counter in the bench closes
// the loop on count; a cycle-level reference model (pending totals, a cooldown
// in cycles, and the last winner) predicts every output each cycle.
module tb_contador_ud_ctrl;

   localparam int W         = 4;
   localparam int MAX_COUNT = 15;
   localparam int P         = 3;
   localparam int GAP       = 4;
   localparam int PEND_MAX  = (1 << P) - 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         inc_req;
   logic         dec_req;
   logic [W-1:0] cnt;
   logic         up, down, full, empty, busy, reject, q_ovf;

   always #5 clk = ~clk;

   contador_ud_ctrl #(
      .W(W), .MAX_COUNT(MAX_COUNT), .P(P), .GAP(GAP)
   ) dut (
      .clk(clk), .reset(reset), .inc_req(inc_req), .dec_req(dec_req),
      .count(cnt), .up(up), .down(down), .full(full), .empty(empty),
      .busy(busy), .reject(reject), .q_ovf(q_ovf)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model state
   int m_pi, m_pd, m_cool;
   bit m_last_inc, m_prev_i, m_prev_d;
   bit e_up, e_down, e_rej, e_ovf;

   // Observation counters, cleared per scenario
   int n_up, n_down, n_rej, n_ovf, first_up, first_down, last_rej, rej_gap;

   task automatic clear_obs();
      n_up = 0; n_down = 0; n_rej = 0; n_ovf = 0;
      first_up = -1; first_down = -1; last_rej = -1; rej_gap = -1;
   endtask

   // One clock cycle: advance the model on the current inputs, clock the DUT,
   // move the bench counter by the strobes, then compare every output.
   task automatic step();
      bit ei, ed, gi, gd, u, d, e_busy, e_full, e_empty;
      cyc++;
      if (reset) begin
         m_pi = 0; m_pd = 0; m_cool = 0; m_last_inc = 1'b0;
         m_prev_i = 1'b0; m_prev_d = 1'b0;
         e_up = 1'b0; e_down = 1'b0; e_rej = 1'b0; e_ovf = 1'b0;
      end else begin
         ei = inc_req && !m_prev_i;
         ed = dec_req && !m_prev_d;
         gi = 1'b0; gd = 1'b0;
         if (m_cool == 0) begin
            if (m_pi > 0 && m_pd > 0) begin
               if (m_last_inc) gd = 1'b1; else gi = 1'b1;
            end else if (m_pi > 0) gi = 1'b1;
            else if (m_pd > 0) gd = 1'b1;
         end else begin
            m_cool--;
         end
         if (gi || gd) begin
            m_cool     = GAP + 1;
            m_last_inc = gi;
         end
         e_up   = gi && (cnt != MAX_COUNT);
         e_down = gd && (cnt != 0);
         e_rej  = (gi && cnt == MAX_COUNT) || (gd && cnt == 0);
         e_ovf  = 1'b0;
         if (ei && !gi) begin
            if (m_pi == PEND_MAX) e_ovf = 1'b1; else m_pi++;
         end else if (!ei && gi) m_pi--;
         if (ed && !gd) begin
            if (m_pd == PEND_MAX) e_ovf = 1'b1; else m_pd++;
         end else if (!ed && gd) m_pd--;
         m_prev_i = inc_req;
         m_prev_d = dec_req;
      end
      u = (up === 1'b1);
      d = (down === 1'b1);
      @(posedge clk);
      #1;
      if (u) cnt = cnt + 4'd1;
      if (d) cnt = cnt - 4'd1;
      @(negedge clk);
      e_busy  = (m_cool > 0) || (m_pi > 0) || (m_pd > 0);
      e_full  = (cnt == MAX_COUNT);
      e_empty = (cnt == 0);
      n_checks++;
      if (up !== e_up) begin n_errors++; $display("FAIL up cyc=%0d got=%b exp=%b", cyc, up, e_up); end
      n_checks++;
      if (down !== e_down) begin n_errors++; $display("FAIL down cyc=%0d got=%b exp=%b", cyc, down, e_down); end
      n_checks++;
      if (reject !== e_rej) begin n_errors++; $display("FAIL reject cyc=%0d got=%b exp=%b", cyc, reject, e_rej); end
      n_checks++;
      if (q_ovf !== e_ovf) begin n_errors++; $display("FAIL q_ovf cyc=%0d got=%b exp=%b", cyc, q_ovf, e_ovf); end
      n_checks++;
      if (busy !== e_busy) begin n_errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      n_checks++;
      if (full !== e_full) begin n_errors++; $display("FAIL full cyc=%0d got=%b exp=%b", cyc, full, e_full); end
      n_checks++;
      if (empty !== e_empty) begin n_errors++; $display("FAIL empty cyc=%0d got=%b exp=%b", cyc, empty, e_empty); end
      n_checks++;
      if ((up & down) !== 1'b0) begin n_errors++; $display("FAIL up_and_down cyc=%0d got=%b exp=0", cyc, up & down); end
      if (up === 1'b1) begin n_up++; if (first_up < 0) first_up = cyc; end
      if (down === 1'b1) begin n_down++; if (first_down < 0) first_down = cyc; end
      if (q_ovf === 1'b1) n_ovf++;
      if (reject === 1'b1) begin
         n_rej++;
         if (last_rej >= 0) rej_gap = cyc - last_rej;
         last_rej = cyc;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; inc_req = 1'b0; dec_req = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      cnt = 4'd7;
      do_reset();
      n_checks++;
      if ({up, down, reject, q_ovf, busy} !== 5'b0) begin
         n_errors++; $display("FAIL reset_outputs got=%b exp=00000", {up, down, reject, q_ovf, busy});
      end
      cnt = 4'd0; #1;
      n_checks++;
      if ({full, empty} !== 2'b01) begin n_errors++; $display("FAIL empty_at_zero got=%b exp=01", {full, empty}); end
      cnt = 4'd15; #1;
      n_checks++;
      if ({full, empty} !== 2'b10) begin n_errors++; $display("FAIL full_at_max got=%b exp=10", {full, empty}); end
   endtask

   task automatic test_single_inc();
      int s;
      cnt = 4'd0;
      do_reset();
      clear_obs();
      step();
      inc_req = 1'b1; s = cyc + 1;
      step();
      inc_req = 1'b0;
      repeat (GAP + 6) step();
      n_checks++;
      if (n_up !== 1) begin n_errors++; $display("FAIL single_up_count got=%0d exp=1", n_up); end
      n_checks++;
      if (first_up !== s + 1) begin n_errors++; $display("FAIL single_up_latency got=%0d exp=%0d", first_up, s + 1); end
      n_checks++;
      if (n_down + n_rej !== 0) begin n_errors++; $display("FAIL single_no_down_rej got=%0d exp=0", n_down + n_rej); end
      n_checks++;
      if (cnt !== 4'd1) begin n_errors++; $display("FAIL single_count got=%0d exp=1", cnt); end
   endtask

   task automatic test_tie();
      int s;
      cnt = 4'd5;
      do_reset();
      clear_obs();
      inc_req = 1'b1; dec_req = 1'b1; s = cyc + 1;
      step();
      inc_req = 1'b0; dec_req = 1'b0;
      repeat (2 * GAP + 8) step();
      n_checks++;
      if (first_up !== s + 1) begin n_errors++; $display("FAIL tie_up_first got=%0d exp=%0d", first_up, s + 1); end
      n_checks++;
      if (first_down !== s + 1 + GAP + 2) begin
         n_errors++; $display("FAIL tie_down_second got=%0d exp=%0d", first_down, s + 1 + GAP + 2);
      end
      n_checks++;
      if (cnt !== 4'd5) begin n_errors++; $display("FAIL tie_count got=%0d exp=5", cnt); end
   endtask

   task automatic test_dec_at_zero();
      cnt = 4'd0;
      do_reset();
      clear_obs();
      dec_req = 1'b1;
      step();
      dec_req = 1'b0;
      repeat (GAP + 6) step();
      n_checks++;
      if (n_rej !== 1) begin n_errors++; $display("FAIL zero_reject_count got=%0d exp=1", n_rej); end
      n_checks++;
      if (n_down !== 0) begin n_errors++; $display("FAIL zero_down_count got=%0d exp=0", n_down); end
      n_checks++;
      if ({cnt, empty, busy} !== {4'd0, 1'b1, 1'b0}) begin
         n_errors++; $display("FAIL zero_final got=%b exp=%b", {cnt, empty, busy}, {4'd0, 1'b1, 1'b0});
      end
   endtask

   task automatic test_inc_at_full();
      cnt = 4'(MAX_COUNT);
      do_reset();
      clear_obs();
      inc_req = 1'b1; step();
      inc_req = 1'b0; step();
      inc_req = 1'b1; step();
      inc_req = 1'b0;
      repeat (2 * GAP + 10) step();
      n_checks++;
      if (n_rej !== 2) begin n_errors++; $display("FAIL full_reject_count got=%0d exp=2", n_rej); end
      n_checks++;
      if (rej_gap !== GAP + 2) begin n_errors++; $display("FAIL full_reject_spacing got=%0d exp=%0d", rej_gap, GAP + 2); end
      n_checks++;
      if (n_up !== 0) begin n_errors++; $display("FAIL full_up_count got=%0d exp=0", n_up); end
      n_checks++;
      if (full !== 1'b1) begin n_errors++; $display("FAIL full_flag got=%b exp=1", full); end
   endtask

   task automatic test_overflow();
      int budget;
      cnt = 4'd0;
      do_reset();
      clear_obs();
      for (int i = 0; i < 14; i++) begin
         inc_req = 1'b1; step();
         inc_req = 1'b0; step();
      end
      budget = 200;
      while (busy !== 1'b0 && budget > 0) begin step(); budget--; end
      n_checks++;
      if (budget == 0) begin n_errors++; $display("FAIL ovf_drain_timeout got=busy exp=idle"); end
      n_checks++;
      if (n_ovf < 1) begin n_errors++; $display("FAIL ovf_seen got=%0d exp>=1", n_ovf); end
      n_checks++;
      if (n_up !== 14 - n_ovf) begin n_errors++; $display("FAIL ovf_up_count got=%0d exp=%0d", n_up, 14 - n_ovf); end
      n_checks++;
      if (cnt !== 4'(n_up)) begin n_errors++; $display("FAIL ovf_count got=%0d exp=%0d", cnt, n_up); end
   endtask

   task automatic test_reset_mid_hold();
      bit found;
      cnt = 4'd0;
      do_reset();
      clear_obs();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         inc_req = ~inc_req;
         step();
         found = (m_cool >= 1) && (m_cool <= GAP) && (m_pi >= 3);
      end
      n_checks++;
      if (!found) begin n_errors++; $display("FAIL hold_setup_timeout got=0 exp=1"); end
      reset = 1'b1; inc_req = 1'b0;
      step();
      n_checks++;
      if ({up, down, reject, q_ovf, busy} !== 5'b0) begin
         n_errors++; $display("FAIL hold_reset_outputs got=%b exp=00000", {up, down, reject, q_ovf, busy});
      end
      reset = 1'b0;
      clear_obs();
      repeat (30) step();
      n_checks++;
      if (n_up + n_down + n_rej !== 0) begin
         n_errors++; $display("FAIL hold_reset_no_ops got=%0d exp=0", n_up + n_down + n_rej);
      end
   endtask

   task automatic test_random();
      int bias_i, bias_d;
      cnt = 4'($urandom_range(0, MAX_COUNT));
      do_reset();
      clear_obs();
      for (int i = 0; i < 3000; i++) begin
         if (i % 300 == 0) begin
            bias_i = $urandom_range(10, 90);
            bias_d = $urandom_range(10, 90);
         end
         reset = ($urandom_range(0, 199) == 0);
         if (reset) cnt = 4'($urandom_range(0, MAX_COUNT));
         inc_req = ($urandom_range(0, 99) < bias_i);
         dec_req = ($urandom_range(0, 99) < bias_d);
         step();
      end
      reset = 1'b0;
      n_checks++;
      if (n_up == 0 || n_down == 0) begin
         n_errors++; $display("FAIL random_activity got=up%0d/down%0d exp=both>0", n_up, n_down);
      end
   endtask

   initial begin
      reset = 1'b1; inc_req = 1'b0; dec_req = 1'b0; cnt = 4'd0;
      clear_obs();
      @(negedge clk);
      test_reset();
      test_single_inc();
      test_tie();
      test_dec_at_zero();
      test_inc_at_full();
      test_overflow();
      test_reset_mid_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
